comparator_4bit: RTL and testbench
==================================

COMPARATOR_4BIT -- requirements
Module: comparator_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; the SHALL statements below use WIDTH=4.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: A  input  WIDTH  operand A.
REQ-006 Port: B  input  WIDTH  operand B.
REQ-007 Port: in_valid  input  1  A/B/signed_mode are sampled on this cycle.
REQ-008 Port: signed_mode  input  1  0 = unsigned compare; 1 = two's-complement compare.
REQ-009 Port: A_gt_B  output  1  A greater than B.
REQ-010 Port: A_lt_B  output  1  A less than B.
REQ-011 Port: A_eq_B  output  1  A equal to B.
REQ-012 Port: out_valid  output  1  flag outputs hold a new result this cycle.
REQ-013 Port: max_out  output  WIDTH  larger operand under the selected mode.
REQ-014 Port: min_out  output  WIDTH  smaller operand under the selected mode.

Function
REQ-015 On a clk edge with in_valid=1 and rst=0, the block SHALL compare A and B and register all results.
REQ-016 Latency SHALL be exactly 1 cycle. out_valid SHALL equal in_valid delayed by one cycle.
REQ-017 Exactly one of A_gt_B, A_lt_B, A_eq_B SHALL be 1 whenever a result has been registered since reset.
REQ-018 Unsigned mode SHALL treat operands as 0..15.
REQ-019 Signed mode SHALL treat operands as -8..7, with bit 3 as the sign bit.
REQ-020 A_eq_B SHALL depend only on bitwise equality, independent of signed_mode.
REQ-021 max_out and min_out SHALL each equal A when A_eq_B=1.
REQ-022 When in_valid=0, the flags, max_out and min_out SHALL hold their previous values, and out_valid SHALL be 0.
REQ-023 Back-to-back in_valid=1 cycles SHALL each produce a result; throughput is 1 per cycle; there is no backpressure.
REQ-024 Out-of-range stimulus is truncated to WIDTH bits by the driver; the block SHALL NOT detect overflow.

Reset
REQ-025 While rst=1 at a clk edge, the block SHALL set outputs as follows, overriding in_valid: A_gt_B=0, A_lt_B=0, A_eq_B=0, out_valid=0, max_out=0, min_out=0.
REQ-026 The first result after reset deasserts SHALL appear one cycle after the first in_valid=1 edge.
REQ-027 If reset is asserted mid-stream, the pending result SHALL be discarded.

Structure
REQ-028 A shared package SHALL hold the default WIDTH constant and a 3-bit compare-result encoding: GT=3'b100, LT=3'b010, EQ=3'b001.
REQ-029 One combinational sub-module, cmp_core, SHALL compute the gt/lt/eq flags from A, B and signed_mode. The top level SHALL hold the registers and the max/min selection.
REQ-030 The block SHALL contain no latches. All outputs SHALL be driven directly from flops.

Verification
REQ-031 Unsigned, A=0x0, B=0x8 -> next cycle: A_lt_B=1, max_out=8, min_out=0, out_valid=1.
REQ-032 Unsigned, A=0x8, B=0x10 (truncates to 0x0) -> A_gt_B=1, max_out=8, min_out=0.
REQ-033 A=0x5, B=0x5, both modes -> A_eq_B=1, max_out=min_out=5.
REQ-034 Unsigned sequence A/B = 2/1, then 1/0, on consecutive cycles -> A_gt_B=1 on two consecutive out_valid cycles.
REQ-035 Signed, A=0x8 (-8), B=0x0 -> A_lt_B=1, min_out=8. The same operands in unsigned mode -> A_gt_B=1.
REQ-036 Assert rst while in_valid=1 -> next cycle all outputs are 0 and out_valid=0. Then set in_valid=0 for 2 cycles -> outputs hold at 0.

Source files
------------

// File: rtl/comparator_4bit_pkg.sv
// Shared constants and compare-result encoding
// for the 4-bit magnitude comparator.
package comparator_4bit_pkg;

  localparam int CMP_WIDTH = 4;

  typedef enum logic [2:0] {
    CMP_GT = 3'b100,
    CMP_LT = 3'b010,
    CMP_EQ = 3'b001
  } cmp_res_e;

endpackage

// File: rtl/comparator_4bit_cmp_core.sv
// Combinational gt/lt/eq decode for two operands,
// unsigned or two's-complement.
module cmp_core
  import comparator_4bit_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output cmp_res_e         res
);

  logic [WIDTH-1:0] a_k;
  logic [WIDTH-1:0] b_k;
  logic             eq;
  logic             lt;

  // Flipping the sign bit maps signed order onto unsigned order.
  always_comb begin
    a_k = a;
    b_k = b;
    if (signed_mode) begin
      a_k[WIDTH-1] = ~a[WIDTH-1];
      b_k[WIDTH-1] = ~b[WIDTH-1];
    end
  end

  assign eq = (a == b);
  assign lt = (a_k < b_k);

  always_comb begin
    res = CMP_GT;
    unique case (1'b1)
      eq:      res = CMP_EQ;
      lt:      res = CMP_LT;
      default: res = CMP_GT;
    endcase
  end

endmodule

// File: rtl/comparator_4bit.sv
// Registered comparator: one-cycle latency flags
// plus max/min selection, result held between inputs.
module comparator_4bit
  import comparator_4bit_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  input  logic             signed_mode,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic             out_valid,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out
);

  cmp_res_e         res;
  logic [WIDTH-1:0] max_d;
  logic [WIDTH-1:0] min_d;

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .a           (A),
    .b           (B),
    .signed_mode (signed_mode),
    .res         (res)
  );

  always_comb begin
    max_d = A;
    min_d = A;
    unique case (res)
      CMP_GT: begin
        max_d = A;
        min_d = B;
      end
      CMP_LT: begin
        max_d = B;
        min_d = A;
      end
      default: begin
        max_d = A;
        min_d = A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A_gt_B    <= 1'b0;
      A_lt_B    <= 1'b0;
      A_eq_B    <= 1'b0;
      out_valid <= 1'b0;
      max_out   <= '0;
      min_out   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        A_gt_B  <= res[2];
        A_lt_B  <= res[1];
        A_eq_B  <= res[0];
        max_out <= max_d;
        min_out <= min_d;
      end
    end
  end

endmodule

// File: tb/tb_comparator_4bit.sv
// Directed self-checking bench for comparator_4bit.
// Inputs change on negedge, outputs sampled #1 after posedge.
module tb_comparator_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       in_valid;
  logic       signed_mode;
  logic       A_gt_B;
  logic       A_lt_B;
  logic       A_eq_B;
  logic       out_valid;
  logic [3:0] max_out;
  logic [3:0] min_out;

  int n_pass;
  int n_total;

  comparator_4bit #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .in_valid    (in_valid),
    .signed_mode (signed_mode),
    .A_gt_B      (A_gt_B),
    .A_lt_B      (A_lt_B),
    .A_eq_B      (A_eq_B),
    .out_valid   (out_valid),
    .max_out     (max_out),
    .min_out     (min_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v,
                      input logic sm, input logic [3:0] a,
                      input logic [3:0] b);
    @(negedge clk);
    rst         = r;
    in_valid    = v;
    signed_mode = sm;
    A           = a;
    B           = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Packs {gt,lt,eq,ov,max,min} for a single comparison.
  function automatic logic [11:0] pk(input logic g, input logic l,
                                     input logic e, input logic o,
                                     input logic [3:0] mx,
                                     input logic [3:0] mn);
    return {g, l, e, o, mx, mn};
  endfunction

  logic [11:0] obs;
  logic [4:0]  wide_b;
  assign obs = {A_gt_B, A_lt_B, A_eq_B, out_valid, max_out, min_out};

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    signed_mode = 1'b0;
    A = 4'h0;
    B = 4'h0;

    step(1, 1, 0, 4'h7, 4'h2);
    chk("reset_state", obs, pk(0, 0, 0, 0, 4'h0, 4'h0));

    step(0, 1, 0, 4'h0, 4'h8);
    chk("u_0_lt_8", obs, pk(0, 1, 0, 1, 4'h8, 4'h0));

    wide_b = 5'h10;
    step(0, 1, 0, 4'h8, wide_b[3:0]);
    chk("u_8_gt_trunc", obs, pk(1, 0, 0, 1, 4'h8, 4'h0));

    step(0, 1, 0, 4'h5, 4'h5);
    chk("u_5_eq_5", obs, pk(0, 0, 1, 1, 4'h5, 4'h5));

    step(0, 1, 1, 4'h5, 4'h5);
    chk("s_5_eq_5", obs, pk(0, 0, 1, 1, 4'h5, 4'h5));

    step(0, 0, 0, 4'h1, 4'hE);
    chk("hold_idle", obs, pk(0, 0, 1, 0, 4'h5, 4'h5));

    step(0, 1, 0, 4'h2, 4'h1);
    chk("b2b_first", obs, pk(1, 0, 0, 1, 4'h2, 4'h1));
    step(0, 1, 0, 4'h1, 4'h0);
    chk("b2b_second", obs, pk(1, 0, 0, 1, 4'h1, 4'h0));

    step(0, 1, 1, 4'h8, 4'h0);
    chk("s_m8_lt_0", obs, pk(0, 1, 0, 1, 4'h0, 4'h8));
    step(0, 1, 0, 4'h8, 4'h0);
    chk("u_8_gt_0", obs, pk(1, 0, 0, 1, 4'h8, 4'h0));

    step(0, 1, 1, 4'h7, 4'h8);
    chk("s_7_gt_m8", obs, pk(1, 0, 0, 1, 4'h7, 4'h8));
    step(0, 1, 1, 4'hF, 4'h1);
    chk("s_m1_lt_1", obs, pk(0, 1, 0, 1, 4'h1, 4'hF));
    step(0, 1, 0, 4'hF, 4'h1);
    chk("u_15_gt_1", obs, pk(1, 0, 0, 1, 4'hF, 4'h1));

    step(1, 1, 0, 4'h3, 4'h9);
    chk("mid_reset", obs, pk(0, 0, 0, 0, 4'h0, 4'h0));
    step(0, 0, 0, 4'h3, 4'h9);
    chk("post_rst_idle1", obs, pk(0, 0, 0, 0, 4'h0, 4'h0));
    step(0, 0, 1, 4'hA, 4'h2);
    chk("post_rst_idle2", obs, pk(0, 0, 0, 0, 4'h0, 4'h0));

    step(0, 1, 0, 4'h9, 4'h3);
    chk("first_after_rst", obs, pk(1, 0, 0, 1, 4'h9, 4'h3));
    step(0, 0, 0, 4'h0, 4'h0);
    chk("ov_drops", obs, pk(1, 0, 0, 0, 4'h9, 4'h3));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
